// File: rtl/eth_rx_ring.sv
// SPI-fed Ethernet frame receiver with a ring of frame slots and MAC filtering.
// The CPU sees the oldest pending frame through a register block and buffer window.
module eth_rx_ring #(
   parameter int          NUM_SLOTS = 4,
   parameter int          SLOT_AW   = 11,
   parameter logic [15:0] REG_BASE  = 16'hFB00,
   parameter logic [15:0] BUF_BASE  = 16'hF000
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        sck,
   input  logic        mosi,
   input  logic        n_ss,
   input  logic [15:0] a,
   input  logic [7:0]  din,
   input  logic        n_we,
   input  logic        n_oe,
   output logic [7:0]  dout,
   output logic        dout_en,
   output logic        frame_irq
);
   localparam int PW    = $clog2(NUM_SLOTS);
   localparam int CW    = SLOT_AW + 1;
   localparam int DEPTH = NUM_SLOTS << SLOT_AW;
   localparam logic [CW-1:0] CAP = CW'(1) << SLOT_AW;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RECV = 2'd1;
   localparam logic [1:0] S_DISC = 2'd2;

   logic [2:0]    r_sck_s, r_ss_s;
   logic [1:0]    r_mosi_s;
   logic [1:0]    r_state;
   logic [2:0]    r_bit_cnt;
   logic [CW-1:0] r_byte_cnt;
   logic [6:0]    r_sh;
   logic          r_match_uc, r_match_bc;
   logic [PW-1:0] r_wr_ptr, r_rd_ptr;
   logic [PW:0]   r_pend;
   logic [7:0]    r_ram [DEPTH];
   logic [CW-1:0] r_len [NUM_SLOTS];
   logic [7:0]    r_mac [6];
   logic          r_promisc;
   logic [7:0]    r_drop;
   logic          r_we_d;
   logic [7:0]    r_dout;
   logic          r_dout_en;
   logic          r_irq;

   logic          w_sck_rise, w_ss_fall, w_ss_rise, w_full;
   logic [7:0]    w_byte, w_mac_b, w_rdata;
   logic          w_byte_done, w_uc, w_bc;
   logic          w_ram_we, w_commit, w_drop_inc, w_release;
   logic          w_reg_sel, w_buf_sel, w_we_fall;
   logic [15:0]   w_len16;

   // Sync flops reset to "n_ss asserted" so a frame already under way at reset release is ignored.
   always_ff @(posedge clk) begin
      if (n_rst) begin
         r_sck_s  <= 3'b000;
         r_ss_s   <= 3'b000;
         r_mosi_s <= 2'b00;
      end else begin
         r_sck_s  <= {r_sck_s[1:0], sck};
         r_ss_s   <= {r_ss_s[1:0], n_ss};
         r_mosi_s <= {r_mosi_s[0], mosi};
      end
   end

   assign w_sck_rise  = r_sck_s[1] & ~r_sck_s[2];
   assign w_ss_fall   = ~r_ss_s[1] & r_ss_s[2];
   assign w_ss_rise   = r_ss_s[1] & ~r_ss_s[2];
   assign w_full      = (r_pend == (PW+1)'(NUM_SLOTS));
   assign w_byte      = {r_sh, r_mosi_s[1]};
   assign w_byte_done = w_sck_rise && (r_bit_cnt == 3'd7) && !w_ss_rise;

   always_comb begin
      w_mac_b = 8'h00;
      case (r_byte_cnt[2:0])
         3'd0: w_mac_b = r_mac[0];
         3'd1: w_mac_b = r_mac[1];
         3'd2: w_mac_b = r_mac[2];
         3'd3: w_mac_b = r_mac[3];
         3'd4: w_mac_b = r_mac[4];
         3'd5: w_mac_b = r_mac[5];
         default: w_mac_b = 8'h00;
      endcase
   end

   assign w_uc       = r_match_uc && (w_byte == w_mac_b);
   assign w_bc       = r_match_bc && (w_byte == 8'hFF);
   assign w_ram_we   = (r_state == S_RECV) && w_byte_done && (r_byte_cnt != CAP);
   assign w_commit   = (r_state == S_RECV) && w_ss_rise && (r_byte_cnt >= CW'(6));
   assign w_drop_inc = ((r_state == S_IDLE) && w_ss_fall && w_full) ||
                       ((r_state == S_RECV) && w_byte_done && (r_byte_cnt == CAP));

   always_ff @(posedge clk) begin
      if (n_rst) begin
         r_state    <= S_IDLE;
         r_bit_cnt  <= 3'd0;
         r_byte_cnt <= '0;
         r_sh       <= 7'd0;
         r_match_uc <= 1'b0;
         r_match_bc <= 1'b0;
      end else if (r_state == S_IDLE) begin
         r_bit_cnt  <= 3'd0;
         r_byte_cnt <= '0;
         if (w_ss_fall) begin
            r_state    <= w_full ? S_DISC : S_RECV;
            r_match_uc <= 1'b1;
            r_match_bc <= 1'b1;
         end
      end else if (w_ss_rise) begin
         r_state    <= S_IDLE;
         r_bit_cnt  <= 3'd0;
         r_byte_cnt <= '0;
      end else if (w_sck_rise) begin
         r_sh      <= w_byte[6:0];
         r_bit_cnt <= r_bit_cnt + 3'd1;
         if (w_byte_done && r_state == S_RECV) begin
            if (r_byte_cnt == CAP) begin
               r_state <= S_DISC;
            end else begin
               r_byte_cnt <= r_byte_cnt + CW'(1);
               if (r_byte_cnt < CW'(6)) begin
                  r_match_uc <= w_uc;
                  r_match_bc <= w_bc;
                  if (r_byte_cnt == CW'(5) && !w_uc && !w_bc && !r_promisc)
                     r_state <= S_DISC;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_ram_we) r_ram[{r_wr_ptr, r_byte_cnt[SLOT_AW-1:0]}] <= w_byte;
      if (w_commit) r_len[r_wr_ptr] <= r_byte_cnt;
   end

   assign w_reg_sel = (a[15:4] == REG_BASE[15:4]);
   assign w_buf_sel = (a[15:SLOT_AW] == BUF_BASE[15:SLOT_AW]);
   assign w_we_fall = r_we_d & ~n_we;
   assign w_release = w_we_fall && w_reg_sel && (a[3:0] == 4'd1) && din[0] && (r_pend != '0);

   // Commit and release in one cycle move both pointers and leave the count alone.
   always_ff @(posedge clk) begin
      if (n_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_pend   <= '0;
      end else begin
         if (w_commit)  r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_release) r_rd_ptr <= r_rd_ptr + PW'(1);
         if (w_commit && !w_release)      r_pend <= r_pend + (PW+1)'(1);
         else if (!w_commit && w_release) r_pend <= r_pend - (PW+1)'(1);
      end
   end

   assign w_len16 = (r_pend != '0) ? 16'(r_len[r_rd_ptr]) : 16'h0000;

   always_comb begin
      w_rdata = 8'h00;
      if (w_reg_sel) begin
         case (a[3:0])
            4'd0:  w_rdata = {4'(r_pend), 2'b00, (r_state != S_IDLE), (r_pend != '0)};
            4'd1:  w_rdata = {6'b0, r_promisc, 1'b0};
            4'd2:  w_rdata = w_len16[7:0];
            4'd3:  w_rdata = w_len16[15:8];
            4'd4:  w_rdata = r_drop;
            4'd8:  w_rdata = r_mac[0];
            4'd9:  w_rdata = r_mac[1];
            4'd10: w_rdata = r_mac[2];
            4'd11: w_rdata = r_mac[3];
            4'd12: w_rdata = r_mac[4];
            4'd13: w_rdata = r_mac[5];
            default: w_rdata = 8'h00;
         endcase
      end else if (w_buf_sel) begin
         w_rdata = r_ram[{r_rd_ptr, a[SLOT_AW-1:0]}];
      end
   end

   always_ff @(posedge clk) begin
      if (n_rst) begin
         for (int i = 0; i < 6; i++) r_mac[i] <= 8'h00;
         r_promisc <= 1'b0;
         r_drop    <= 8'h00;
         r_we_d    <= 1'b1;
         r_dout    <= 8'h00;
         r_dout_en <= 1'b0;
         r_irq     <= 1'b0;
      end else begin
         r_we_d <= n_we;
         r_irq  <= (r_pend != '0);
         if (!n_oe && (w_reg_sel || w_buf_sel)) begin
            r_dout    <= w_rdata;
            r_dout_en <= 1'b1;
         end else begin
            r_dout_en <= 1'b0;
         end
         if (!n_we && w_reg_sel) begin
            if (a[3:0] == 4'd1) r_promisc <= din[1];
            if (a[3:0] >= 4'd8 && a[3:0] <= 4'd13) r_mac[a[2:0]] <= din;
         end
         if (!n_we && w_reg_sel && a[3:0] == 4'd1 && din[7])
            r_drop <= 8'h00;
         else if (w_drop_inc && r_drop != 8'hFF)
            r_drop <= r_drop + 8'd1;
      end
   end

   assign dout      = r_dout;
   assign dout_en   = r_dout_en;
   assign frame_irq = r_irq;
endmodule

// File: tb/tb_eth_rx_ring.sv
// Randomised bench for eth_rx_ring: frames are scored against a queue-based
// model of the receive ring; CPU reads are checked by a monitor on dout_en.
`timescale 1ns/1ps
module tb_eth_rx_ring;
   localparam int NS = 4;
   localparam int SAW = 7;
   localparam int CAP = 1 << SAW;
   localparam logic [15:0] REG = 16'hFB00;
   localparam logic [15:0] BUF = 16'hF000;

   logic clk = 1'b0;
   logic n_rst, sck, mosi, n_ss, n_we, n_oe;
   logic [15:0] a;
   logic [7:0] din;
   logic [7:0] dout;
   logic dout_en, frame_irq;

   eth_rx_ring #(.NUM_SLOTS(NS), .SLOT_AW(SAW), .REG_BASE(REG), .BUF_BASE(BUF)) dut (
      .clk(clk), .n_rst(n_rst), .sck(sck), .mosi(mosi), .n_ss(n_ss),
      .a(a), .din(din), .n_we(n_we), .n_oe(n_oe),
      .dout(dout), .dout_en(dout_en), .frame_irq(frame_irq)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];
   string name_q[$];

   // reference model: pending frames as a FIFO of (start,len) into a byte arena
   logic [7:0] m_mac[6];
   bit m_promisc;
   int m_drop;
   logic [7:0] arena[$];
   int fr_start[$];
   int fr_len[$];
   logic [7:0] tx_q[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (!n_rst && dout_en) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_read actual=%0h required=no_read", dout);
         end else begin
            logic [7:0] e;
            string nm;
            e = exp_q.pop_front();
            nm = name_q.pop_front();
            if (dout !== e) begin
               errors++;
               $display("FAIL %s actual=%0h required=%0h", nm, dout, e);
            end
         end
      end
   end

   task automatic rd(input logic [15:0] addr, input logic [7:0] e, input string nm);
      exp_q.push_back(e);
      name_q.push_back(nm);
      a = addr;
      n_oe = 1'b0;
      @(negedge clk);
      n_oe = 1'b1;
      @(negedge clk);
   endtask

   task automatic wr(input logic [3:0] off, input logic [7:0] v);
      a = REG + 16'(off);
      din = v;
      n_we = 1'b0;
      @(negedge clk);
      n_we = 1'b1;
      @(negedge clk);
      if (off == 4'd1) begin
         m_promisc = v[1];
         if (v[7]) m_drop = 0;
         if (v[0] && fr_len.size() > 0) begin
            void'(fr_start.pop_front());
            void'(fr_len.pop_front());
         end
      end
      if (off >= 4'd8 && off <= 4'd13) m_mac[off-4'd8] = v;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 6; i++) m_mac[i] = 8'h00;
      m_promisc = 1'b0;
      m_drop = 0;
      fr_start.delete();
      fr_len.delete();
   endtask

   // frame acceptance decided from the rules: ring space, runt, filter, capacity
   task automatic model_rx();
      int n;
      bit uc, bc;
      n = tx_q.size();
      uc = 1'b1;
      bc = 1'b1;
      if (fr_len.size() >= NS) begin
         if (m_drop < 255) m_drop++;
         return;
      end
      if (n < 6) return;
      for (int i = 0; i < 6; i++) begin
         if (tx_q[i] != m_mac[i]) uc = 1'b0;
         if (tx_q[i] != 8'hFF) bc = 1'b0;
      end
      if (!uc && !bc && !m_promisc) return;
      if (n > CAP) begin
         if (m_drop < 255) m_drop++;
         return;
      end
      fr_start.push_back(arena.size());
      fr_len.push_back(n);
      for (int i = 0; i < n; i++) arena.push_back(tx_q[i]);
   endtask

   // kind 0: station address, 1: broadcast, 2: foreign unicast
   task automatic build(input int kind, input int len);
      tx_q.delete();
      for (int i = 0; i < len; i++) begin
         if (i < 6) begin
            case (kind)
               0: tx_q.push_back(m_mac[i]);
               1: tx_q.push_back(8'hFF);
               default: tx_q.push_back(m_mac[i] ^ ((i == 5) ? 8'h5A : 8'h00));
            endcase
         end else begin
            tx_q.push_back(8'($urandom_range(0, 255)));
         end
      end
   endtask

   task automatic send_bytes(input int from, input int to);
      for (int k = from; k < to; k++) begin
         logic [7:0] b;
         b = tx_q[k];
         for (int i = 7; i >= 0; i--) begin
            mosi = b[i];
            sck = 1'b0;
            repeat (4) @(negedge clk);
            sck = 1'b1;
            repeat (4) @(negedge clk);
         end
      end
   endtask

   task automatic send(input bit rel);
      model_rx();
      n_ss = 1'b0;
      repeat (4) @(negedge clk);
      send_bytes(0, tx_q.size());
      sck = 1'b0;
      repeat (4) @(negedge clk);
      n_ss = 1'b1;
      if (rel) begin
         repeat (2) @(negedge clk);
         wr(4'd1, 8'h01);
      end
      repeat (6) @(negedge clk);
   endtask

   task automatic check_status();
      int p;
      logic [7:0] e;
      p = fr_len.size();
      e = {4'(p), 3'b000, (p != 0)};
      rd(REG + 16'd0, e, "status");
      rd(REG + 16'd4, 8'(m_drop), "drop_cnt");
   endtask

   task automatic check_head(input bit full);
      int l, s, off;
      if (fr_len.size() == 0) begin
         rd(REG + 16'd2, 8'h00, "len_lo_empty");
         rd(REG + 16'd3, 8'h00, "len_hi_empty");
         return;
      end
      l = fr_len[0];
      s = fr_start[0];
      rd(REG + 16'd2, 8'(l), "len_lo");
      rd(REG + 16'd3, 8'(l >> 8), "len_hi");
      if (full) begin
         for (int i = 0; i < l; i++) rd(BUF + 16'(i), arena[s+i], "window");
      end else begin
         off = $urandom_range(0, l - 1);
         rd(BUF + 16'd0, arena[s], "window_first");
         rd(BUF + 16'(l - 1), arena[s+l-1], "window_last");
         rd(BUF + 16'(off), arena[s+off], "window_rand");
      end
   endtask

   task automatic set_mac();
      wr(4'd8, 8'h02); wr(4'd9, 8'h00); wr(4'd10, 8'h00);
      wr(4'd11, 8'h00); wr(4'd12, 8'h00); wr(4'd13, 8'h01);
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_rst = 1'b1; sck = 1'b0; mosi = 1'b0; n_ss = 1'b1;
      a = 16'h0000; din = 8'h00; n_we = 1'b1; n_oe = 1'b1;
      model_reset();
      repeat (4) @(negedge clk);
      n_rst = 1'b0;
      @(negedge clk);
      check("reset_dout", 32'(dout), 32'h0);
      check("reset_dout_en", 32'(dout_en), 32'h0);
      check("reset_irq", 32'(frame_irq), 32'h0);
      check_status();
      rd(REG + 16'd1, 8'h00, "ctrl_reset");
      rd(REG + 16'd8, 8'h00, "mac0_reset");

      // unmapped address: no read strobe must be returned
      a = 16'h1234;
      n_oe = 1'b0;
      @(negedge clk);
      check("unmapped_dout_en", 32'(dout_en), 32'h0);
      n_oe = 1'b1;
      @(negedge clk);

      // station frame, full window readback, release
      set_mac();
      rd(REG + 16'd8, 8'h02, "mac0");
      rd(REG + 16'd13, 8'h01, "mac5");
      build(0, 64);
      send(1'b0);
      check_status();
      check("irq_pending", 32'(frame_irq), 32'h1);
      check_head(1'b1);
      wr(4'd1, 8'h01);
      check_status();
      repeat (2) @(negedge clk);
      check("irq_released", 32'(frame_irq), 32'h0);

      // broadcast accepted, foreign unicast rejected without drop count
      build(1, 16);
      send(1'b0);
      build(2, 20);
      send(1'b0);
      check_status();
      check_head(1'b0);

      // fill the ring, overflow once, release, refill across the wrap
      for (int i = 0; i < 3; i++) begin
         build($urandom_range(0, 1), $urandom_range(8, 14));
         send(1'b0);
      end
      check_status();
      build(0, 10);
      send(1'b0);
      check_status();
      wr(4'd1, 8'h01);
      build(0, 12);
      send(1'b0);
      check_status();
      for (int i = 0; i < NS; i++) begin
         check_head(1'b0);
         wr(4'd1, 8'h01);
      end
      check_status();

      // capacity boundary
      wr(4'd1, 8'h80);
      build(0, CAP + 1);
      send(1'b0);
      check_status();
      build(0, CAP);
      send(1'b0);
      check_status();
      check_head(1'b0);
      wr(4'd1, 8'h01);

      // commit and release in the same cycle, then a runt
      build(0, 8);
      send(1'b0);
      build(1, 9);
      send(1'b0);
      build(0, 10);
      send(1'b1);
      check_status();
      check_head(1'b0);
      build(0, 5);
      send(1'b0);
      check_status();

      // randomised traffic
      for (int r = 0; r < 8; r++) begin
         if ($urandom_range(0, 3) == 0) wr(4'd1, {6'b0, 1'($urandom_range(0, 1)), 1'b0});
         if (fr_len.size() > 0 && $urandom_range(0, 1) == 1) wr(4'd1, {6'b0, m_promisc, 1'b1});
         build($urandom_range(0, 2), $urandom_range(3, 24));
         send(1'b0);
         check_status();
         check_head(1'b0);
         rd(REG + 16'd1, {6'b0, m_promisc, 1'b0}, "ctrl");
      end

      // reset in the middle of a frame
      build(0, 40);
      n_ss = 1'b0;
      repeat (4) @(negedge clk);
      send_bytes(0, 20);
      n_rst = 1'b1;
      repeat (3) @(negedge clk);
      n_rst = 1'b0;
      model_reset();
      send_bytes(20, 40);
      sck = 1'b0;
      repeat (4) @(negedge clk);
      n_ss = 1'b1;
      repeat (6) @(negedge clk);
      check_status();
      check_head(1'b0);
      rd(REG + 16'd1, 8'h00, "ctrl_after_reset");
      for (int i = 0; i < 6; i++) rd(REG + 16'(8 + i), 8'h00, "mac_after_reset");
      check("irq_after_reset", 32'(frame_irq), 32'h0);
      set_mac();
      build(0, 20);
      send(1'b0);
      check_status();
      check_head(1'b1);

      repeat (10) @(negedge clk);
      if (exp_q.size() != 0) begin
         errors += exp_q.size();
         $display("FAIL reads_outstanding actual=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
